// File: rtl/pid_sample_scheduler.sv
// Fixed-rate sequencer for the PID loop: paces pid_start from an external cycle timer,
// hands each result to the UART and counts missed sample periods.
module pid_sample_scheduler #(
    parameter int unsigned CNT_W    = 64,
    parameter int unsigned PERIOD_W = 32,
    parameter int unsigned OVR_W    = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic [PERIOD_W-1:0] period_cycles_i,
    input  logic                tx_en_i,
    input  logic [CNT_W-1:0]    timer_count_i,
    input  logic                timer_overflow_i,
    output logic                timer_reset_o,
    output logic                pid_start_o,
    input  logic                pid_done_i,
    output logic                tx_start_o,
    input  logic                tx_done_i,
    input  logic                clear_overrun_i,
    output logic                busy_o,
    output logic                overrun_o,
    output logic [OVR_W-1:0]    overrun_count_o,
    output logic [PERIOD_W-1:0] sample_count_o
);

    typedef enum logic [1:0] {StIdle, StWait, StPidBusy, StTxBusy} state_e;

    state_e              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] period_clamped;
    logic [PERIOD_W-1:0] period_m2;
    logic [CNT_W-1:0]    due_thresh;
    logic                due;
    logic                overrun_hit;
    logic                timer_reset_q, timer_reset_d;
    logic                pid_start_q, pid_start_d;
    logic                tx_start_q, tx_start_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;
    logic [OVR_W-1:0]    overrun_count_q, overrun_count_d;
    logic [PERIOD_W-1:0] sample_count_q, sample_count_d;

    assign period_clamped = (period_cycles_i < PERIOD_W'(2)) ? PERIOD_W'(2) : period_cycles_i;
    assign period_m2      = period_q - PERIOD_W'(2);
    assign due_thresh     = CNT_W'(period_m2);

    // Decide one cycle early (count >= P-2) so the registered pulses land on the cycle the
    // timer reads P-1. The count is stale while our own timer_reset is still on the wire.
    assign due = !timer_reset_q && ((timer_count_i >= due_thresh) || timer_overflow_i);

    always_comb begin
        state_d         = state_q;
        period_d        = period_q;
        timer_reset_d   = 1'b0;
        pid_start_d     = 1'b0;
        tx_start_d      = 1'b0;
        overrun_d       = overrun_q;
        overrun_count_d = overrun_count_q;
        sample_count_d  = sample_count_q;
        overrun_hit     = 1'b0;

        if (!enable_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    timer_reset_d = 1'b1;
                    period_d      = period_clamped;
                    state_d       = StWait;
                end
                StWait: begin
                    if (due) begin
                        timer_reset_d  = 1'b1;
                        pid_start_d    = 1'b1;
                        sample_count_d = sample_count_q + 1'b1;
                        period_d       = period_clamped;
                        state_d        = StPidBusy;
                    end
                end
                StPidBusy: begin
                    if (pid_done_i) begin
                        tx_start_d = tx_en_i;
                        state_d    = tx_en_i ? StTxBusy : StWait;
                    end
                    overrun_hit = due;
                end
                StTxBusy: begin
                    if (tx_done_i) begin
                        state_d = StWait;
                    end
                    overrun_hit = due;
                end
                default: state_d = StIdle;
            endcase
        end

        // Missed period: restart the timer and drop this sample.
        if (overrun_hit) begin
            timer_reset_d = 1'b1;
            period_d      = period_clamped;
            overrun_d     = 1'b1;
            if (overrun_count_q != {OVR_W{1'b1}}) begin
                overrun_count_d = overrun_count_q + 1'b1;
            end
        end

        if (clear_overrun_i) begin
            overrun_d       = 1'b0;
            overrun_count_d = '0;
        end

        busy_d = (state_d == StPidBusy) || (state_d == StTxBusy);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= StIdle;
            period_q        <= PERIOD_W'(2);
            timer_reset_q   <= 1'b0;
            pid_start_q     <= 1'b0;
            tx_start_q      <= 1'b0;
            busy_q          <= 1'b0;
            overrun_q       <= 1'b0;
            overrun_count_q <= '0;
            sample_count_q  <= '0;
        end else begin
            state_q         <= state_d;
            period_q        <= period_d;
            timer_reset_q   <= timer_reset_d;
            pid_start_q     <= pid_start_d;
            tx_start_q      <= tx_start_d;
            busy_q          <= busy_d;
            overrun_q       <= overrun_d;
            overrun_count_q <= overrun_count_d;
            sample_count_q  <= sample_count_d;
        end
    end

    assign timer_reset_o   = timer_reset_q;
    assign pid_start_o     = pid_start_q;
    assign tx_start_o      = tx_start_q;
    assign busy_o          = busy_q;
    assign overrun_o       = overrun_q;
    assign overrun_count_o = overrun_count_q;
    assign sample_count_o  = sample_count_q;

endmodule

// File: tb/tb_pid_sample_scheduler.sv
// Bench for pid_sample_scheduler: a tick-schedule model checked every cycle, a timer and
// PID/UART responders, and directed scenarios with hand-computed expectations.
module tb_pid_sample_scheduler;

    localparam int CNT_W    = 64;
    localparam int PERIOD_W = 32;
    localparam int OVR_W    = 8;
    localparam int OVR_MAX  = (1 << OVR_W) - 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                enable = 1'b0;
    logic [PERIOD_W-1:0] period_cycles = 32'd10;
    logic                tx_en = 1'b0;
    logic [CNT_W-1:0]    timer_count = '0;
    logic                timer_overflow;
    logic                timer_reset;
    logic                pid_start;
    logic                pid_done = 1'b0;
    logic                tx_start;
    logic                tx_done = 1'b0;
    logic                clear_overrun = 1'b0;
    logic                busy;
    logic                overrun;
    logic [OVR_W-1:0]    overrun_count;
    logic [PERIOD_W-1:0] sample_count;

    always #5 clk = ~clk;

    pid_sample_scheduler #(
        .CNT_W    (CNT_W),
        .PERIOD_W (PERIOD_W),
        .OVR_W    (OVR_W)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .enable_i         (enable),
        .period_cycles_i  (period_cycles),
        .tx_en_i          (tx_en),
        .timer_count_i    (timer_count),
        .timer_overflow_i (timer_overflow),
        .timer_reset_o    (timer_reset),
        .pid_start_o      (pid_start),
        .pid_done_i       (pid_done),
        .tx_start_o       (tx_start),
        .tx_done_i        (tx_done),
        .clear_overrun_i  (clear_overrun),
        .busy_o           (busy),
        .overrun_o        (overrun),
        .overrun_count_o  (overrun_count),
        .sample_count_o   (sample_count)
    );

    // Free-running saturating timer: reads 0 the cycle after timer_reset.
    always @(posedge clk) begin
        if (timer_reset) timer_count <= '0;
        else if (timer_count != '1) timer_count <= timer_count + 1'b1;
    end
    assign timer_overflow = (timer_count == '1);

    int checks = 0;
    int errors = 0;
    longint cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: a sample (or an overrun) is due exactly P cycles after the last timer_reset.
    int          m_mode = 0;  // 0 idle, 1 wait, 2 pid, 3 tx
    longint      m_tr = 0;
    longint      m_p = 2;
    logic [31:0] m_samples = 0;
    int          m_ocnt = 0;
    bit          m_ovr = 0;
    bit          e_tr = 0, e_ps = 0, e_tx = 0;

    function automatic longint clampp(input logic [31:0] v);
        return (v < 2) ? 64'd2 : {32'd0, v};
    endfunction

    always @(posedge clk) begin
        bit tick;
        bit miss;
        cyc++;
        e_tr = 0; e_ps = 0; e_tx = 0;
        if (reset) begin
            m_mode = 0; m_samples = 0; m_ocnt = 0; m_ovr = 0;
        end else begin
            tick = (cyc == m_tr + m_p);
            miss = 0;
            if (!enable) m_mode = 0;
            else if (m_mode == 0) begin
                e_tr = 1; m_tr = cyc; m_p = clampp(period_cycles); m_mode = 1;
            end else if (m_mode == 1) begin
                if (tick) begin
                    e_ps = 1; e_tr = 1; m_samples++;
                    m_tr = cyc; m_p = clampp(period_cycles); m_mode = 2;
                end
            end else if (m_mode == 2) begin
                if (pid_done) begin e_tx = tx_en; m_mode = tx_en ? 3 : 1; end
                miss = tick;
            end else begin
                if (tx_done) m_mode = 1;
                miss = tick;
            end
            if (miss) begin
                e_tr = 1; m_tr = cyc; m_p = clampp(period_cycles); m_ovr = 1;
                if (m_ocnt < OVR_MAX) m_ocnt++;
            end
            if (clear_overrun) begin m_ovr = 0; m_ocnt = 0; end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("timer_reset", 64'(timer_reset), 64'(e_tr));
            chk("pid_start", 64'(pid_start), 64'(e_ps));
            chk("tx_start", 64'(tx_start), 64'(e_tx));
            chk("busy", 64'(busy), 64'(m_mode >= 2));
            chk("overrun", 64'(overrun), 64'(m_ovr));
            chk("overrun_count", 64'(overrun_count), 64'(m_ocnt));
            chk("sample_count", 64'(sample_count), 64'(m_samples));
        end
    end

    // PID/UART responders and pulse logs.
    int     pid_lat = 2, tx_lat = 4, pid_cd = 0, tx_cd = 0;
    bit     pid_hold = 0;
    longint ps_q[$], tx_q[$], tr_q[$];

    always @(negedge clk) begin
        pid_done = 1'b0;
        tx_done  = 1'b0;
        if (pid_cd > 0) begin pid_cd--; if (pid_cd == 0) pid_done = 1'b1; end
        if (tx_cd > 0) begin tx_cd--; if (tx_cd == 0) tx_done = 1'b1; end
        if (pid_start && !pid_hold) begin
            if (pid_lat == 0) pid_done = 1'b1; else pid_cd = pid_lat;
        end
        if (tx_start) begin
            if (tx_lat == 0) tx_done = 1'b1; else tx_cd = tx_lat;
        end
        if (timer_reset) tr_q.push_back(cyc);
        if (pid_start) ps_q.push_back(cyc);
        if (tx_start) tx_q.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic step_to(input longint c);
        while (cyc < c) step(1);
    endtask

    task automatic wait_ps(input int n);
        int guard = 0;
        while (ps_q.size() < n && guard < 400) begin step(1); guard++; end
        chk("pid_start_count_reached", 64'(ps_q.size()), 64'(n));
    endtask

    task automatic restart(input logic [31:0] per, input bit ten);
        enable = 0; reset = 1;
        step(3);
        reset = 0;
        ps_q.delete(); tx_q.delete(); tr_q.delete();
        period_cycles = per; tx_en = ten;
        enable = 1;
    endtask

    initial begin
        longint s;
        step(3);
        chk("reset_sample_count", 64'(sample_count), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_overrun_count", 64'(overrun_count), 64'd0);
        chk("reset_timer_reset", 64'(timer_reset), 64'd0);

        // 1: steady loop, P=10, TX enabled
        pid_lat = 2; tx_lat = 4;
        restart(32'd10, 1'b1);
        wait_ps(5);
        chk("t1_sample_count", 64'(sample_count), 64'd5);
        chk("t1_overrun", 64'(overrun), 64'd0);
        chk("t1_first_start", 64'(ps_q[0] - tr_q[0]), 64'd10);
        for (int i = 1; i < 5; i++) chk("t1_interval", 64'(ps_q[i] - ps_q[i-1]), 64'd10);
        chk("t1_tx_after_start", 64'(tx_q[0] - ps_q[0]), 64'd3);

        // 2: pid_done stalled 25 cycles, P=10
        pid_lat = 25;
        restart(32'd10, 1'b0);
        wait_ps(1);
        s = ps_q[0];
        step_to(s + 29);
        chk("t2_overrun", 64'(overrun), 64'd1);
        chk("t2_overrun_count", 64'(overrun_count), 64'd2);
        chk("t2_no_start_in_stall", 64'(ps_q.size()), 64'd1);
        pid_lat = 2;
        wait_ps(2);
        chk("t2_next_start", 64'(ps_q[1] - s), 64'd30);
        chk("t2_start_after_tr", 64'(ps_q[1] - tr_q[tr_q.size()-2]), 64'd10);

        // 3: period 0 clamps to 2, immediate done
        pid_lat = 0;
        restart(32'd0, 1'b0);
        wait_ps(4);
        chk("t3_first_start", 64'(ps_q[0] - tr_q[0]), 64'd2);
        for (int i = 1; i < 4; i++) chk("t3_interval", 64'(ps_q[i] - ps_q[i-1]), 64'd2);
        chk("t3_overrun", 64'(overrun), 64'd0);

        // 4: period change mid-interval
        pid_lat = 2; tx_lat = 4;
        restart(32'd10, 1'b1);
        wait_ps(1);
        step(4);
        period_cycles = 32'd20;
        wait_ps(3);
        chk("t4_interval_old", 64'(ps_q[1] - ps_q[0]), 64'd10);
        chk("t4_interval_new", 64'(ps_q[2] - ps_q[1]), 64'd20);

        // 5: enable dropped in TX_BUSY, late tx_done, re-enable
        tx_lat = 6;
        restart(32'd10, 1'b1);
        wait_ps(2);
        s = ps_q[1];
        step_to(s + 4);
        enable = 0;
        step_to(s + 12);
        chk("t5_idle_busy", 64'(busy), 64'd0);
        chk("t5_counter_kept", 64'(sample_count), 64'd2);
        chk("t5_no_start", 64'(ps_q.size()), 64'd2);
        enable = 1;
        wait_ps(3);
        chk("t5_reenable_tr", 64'(tr_q[tr_q.size()-2]), 64'(s + 13));
        chk("t5_first_start", 64'(ps_q[2]), 64'(s + 23));
        chk("t5_sample_count", 64'(sample_count), 64'd3);
        tx_lat = 4;

        // 6: saturate overrun_count, then clear together with an overrun
        pid_hold = 1;
        restart(32'd2, 1'b0);
        wait_ps(1);
        s = ps_q[0];
        step_to(s + 520);
        chk("t6_saturated", 64'(overrun_count), 64'(OVR_MAX));
        chk("t6_overrun_set", 64'(overrun), 64'd1);
        step(1);
        clear_overrun = 1;
        step(1);
        clear_overrun = 0;
        chk("t6_clear_overrun", 64'(overrun), 64'd0);
        chk("t6_clear_count", 64'(overrun_count), 64'd0);
        chk("t6_overrun_tr", 64'(timer_reset), 64'd1);
        step(2);
        chk("t6_count_resumes", 64'(overrun_count), 64'd1);
        pid_hold = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog @cycle %0d: got timeout expected completion", cyc);
        $fatal(1, "watchdog");
    end

endmodule
